// File: rtl/regfile_cfg.sv
// regfile_cfg: parametrised system register file
// bus read/write, read-only mask, error strobe, change-detect pulses
module regfile_cfg #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned N_EXPOSE   = 4,
  parameter logic [DEPTH-1:0]      RO_MASK  = '0,
  parameter logic [DATA_WIDTH-1:0] REG2_RST = 8'h81,
  parameter logic [DATA_WIDTH-1:0] REG3_RST = 8'h20
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [DATA_WIDTH-1:0]          WrData,
  input  logic [ADDR_WIDTH-1:0]          Address,
  input  logic                           WR_En,
  input  logic                           RD_EN,
  output logic [DATA_WIDTH-1:0]          RdData,
  output logic                           RdData_Vaild,
  output logic                           ERR,
  output logic [N_EXPOSE-1:0]            CFG_UPD,
  output logic [N_EXPOSE*DATA_WIDTH-1:0] REG_OUT
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvld_q;
  logic                  err_q;
  logic [N_EXPOSE-1:0]   upd_q;

  logic [IW-1:0]       idx;
  logic                in_rng;
  logic                wr_ok;
  logic                rd_ok;
  logic                err_d;
  logic                chg;
  logic [N_EXPOSE-1:0] upd_d;

  function automatic logic [DATA_WIDTH-1:0] rst_val(input int i);
    if (i == 2)      return REG2_RST;
    else if (i == 3) return REG3_RST;
    else             return '0;
  endfunction

  assign idx    = Address[IW-1:0];
  assign in_rng = 32'(Address) < DEPTH;

  // access decode: legal write / legal read / illegal
  always_comb begin
    wr_ok = 1'b0;
    rd_ok = 1'b0;
    err_d = 1'b0;
    chg   = 1'b0;
    if (WR_En && RD_EN) begin
      err_d = 1'b1;
    end else if (WR_En || RD_EN) begin
      if (!in_rng) begin
        err_d = 1'b1;
      end else if (WR_En) begin
        if (RO_MASK[idx]) err_d = 1'b1;
        else              wr_ok = 1'b1;
        chg = WrData != mem_q[idx];
      end else begin
        rd_ok = 1'b1;
      end
    end
  end

  // one-hot change strobe for exposed registers
  always_comb begin
    upd_d = '0;
    if (wr_ok && chg) begin
      for (int i = 0; i < int'(N_EXPOSE); i++) begin
        if (idx == IW'(i)) upd_d[i] = 1'b1;
      end
    end
  end

  // storage with per-register reset values
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= rst_val(i);
      end
    end else if (wr_ok) begin
      mem_q[idx] <= WrData;
    end
  end

  // registered read data and one-cycle strobes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      err_q   <= 1'b0;
      upd_q   <= '0;
    end else begin
      rvld_q <= rd_ok;
      err_q  <= err_d;
      upd_q  <= upd_d;
      if (rd_ok) rdata_q <= mem_q[idx];
    end
  end

  for (genvar g = 0; g < int'(N_EXPOSE); g++) begin : g_out
    assign REG_OUT[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
  end

  assign RdData       = rdata_q;
  assign RdData_Vaild = rvld_q;
  assign ERR          = err_q;
  assign CFG_UPD      = upd_q;

endmodule

// File: tb/tb_regfile_cfg.sv
// tb_regfile_cfg: directed bench for regfile_cfg
// ADDR_WIDTH=5 so an out-of-range address (16) is reachable
module tb_regfile_cfg;

  logic        CLK;
  logic        RST;
  logic [7:0]  WrData;
  logic [4:0]  Address;
  logic        WR_En;
  logic        RD_EN;
  logic [7:0]  RdData;
  logic        RdData_Vaild;
  logic        ERR;
  logic [3:0]  CFG_UPD;
  logic [31:0] REG_OUT;

  int tests;
  int fails;

  regfile_cfg #(
    .DATA_WIDTH(8),
    .DEPTH(16),
    .ADDR_WIDTH(5),
    .N_EXPOSE(4),
    .RO_MASK(16'h0002),
    .REG2_RST(8'h81),
    .REG3_RST(8'h20)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .WrData(WrData),
    .Address(Address),
    .WR_En(WR_En),
    .RD_EN(RD_EN),
    .RdData(RdData),
    .RdData_Vaild(RdData_Vaild),
    .ERR(ERR),
    .CFG_UPD(CFG_UPD),
    .REG_OUT(REG_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic we, input logic re,
                     input logic [4:0] a, input logic [7:0] d);
    WR_En   = we;
    RD_EN   = re;
    Address = a;
    WrData  = d;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic strb(input string tag, input logic v,
                      input logic e, input logic [3:0] u);
    chk({tag, "_vld"}, 32'(RdData_Vaild), 32'(v));
    chk({tag, "_err"}, 32'(ERR), 32'(e));
    chk({tag, "_upd"}, 32'(CFG_UPD), 32'(u));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RST = 1'b0;
    drv(0, 0, 0, 0);
    cyc();
    cyc();
    chk("rst_rd", 32'(RdData), 32'h0);
    strb("rst", 0, 0, 4'b0000);
    chk("rst_regout", REG_OUT, 32'h2081_0000);
    RST = 1'b1;
    cyc();
    strb("idle", 0, 0, 4'b0000);

    // back-to-back reads of reset values
    drv(0, 1, 2, 0);
    cyc();
    strb("b2b0", 1, 0, 4'b0000);
    chk("b2b0_d", 32'(RdData), 32'h81);
    drv(0, 1, 3, 0);
    cyc();
    strb("b2b1", 1, 0, 4'b0000);
    chk("b2b1_d", 32'(RdData), 32'h20);
    drv(0, 1, 0, 0);
    cyc();
    strb("b2b2", 1, 0, 4'b0000);
    chk("b2b2_d", 32'(RdData), 32'h00);

    // write then read addr 0
    drv(1, 0, 0, 8'h5A);
    cyc();
    strb("wr0", 0, 0, 4'b0001);
    chk("wr0_out", REG_OUT, 32'h2081_005A);
    drv(0, 1, 0, 0);
    cyc();
    strb("rd0", 1, 0, 4'b0000);
    chk("rd0_d", 32'(RdData), 32'h5A);
    drv(0, 0, 0, 0);
    cyc();
    strb("rd0_idle", 0, 0, 4'b0000);
    chk("rd0_hold", 32'(RdData), 32'h5A);

    // same-value rewrite, then change
    drv(1, 0, 2, 8'h81);
    cyc();
    strb("same2", 0, 0, 4'b0000);
    drv(1, 0, 2, 8'h83);
    cyc();
    strb("chg2", 0, 0, 4'b0100);
    chk("chg2_out", 32'(REG_OUT[23:16]), 32'h83);
    drv(0, 0, 0, 0);
    cyc();
    strb("chg2_idle", 0, 0, 4'b0000);

    // read-only register
    drv(1, 0, 1, 8'hFF);
    cyc();
    strb("ro1", 0, 1, 4'b0000);
    drv(0, 1, 1, 0);
    cyc();
    strb("ro1_rd", 1, 0, 4'b0000);
    chk("ro1_d", 32'(RdData), 32'h00);

    // illegal: out of range, then both enables (consecutive)
    drv(1, 0, 16, 8'h11);
    cyc();
    strb("oor_wr", 0, 1, 4'b0000);
    drv(1, 1, 0, 8'h33);
    cyc();
    strb("both", 0, 1, 4'b0000);
    drv(0, 1, 16, 0);
    cyc();
    strb("oor_rd", 0, 1, 4'b0000);
    drv(0, 1, 0, 0);
    cyc();
    strb("both_chk", 1, 0, 4'b0000);
    chk("both_mem", 32'(RdData), 32'h5A);

    // read right after write returns new value
    drv(1, 0, 3, 8'h07);
    cyc();
    strb("wr3", 0, 0, 4'b1000);
    drv(0, 1, 3, 0);
    cyc();
    strb("rd3", 1, 0, 4'b0000);
    chk("rd3_d", 32'(RdData), 32'h07);

    // reset while a read is pending
    drv(0, 1, 0, 0);
    #3;
    RST = 1'b0;
    #1;
    strb("mid_rst", 0, 0, 4'b0000);
    chk("mid_rst_out", REG_OUT, 32'h2081_0000);
    cyc();
    drv(0, 0, 0, 0);
    RST = 1'b1;
    cyc();
    strb("post_rst", 0, 0, 4'b0000);
    chk("post_rst_rd", 32'(RdData), 32'h0);
    drv(0, 1, 0, 0);
    cyc();
    strb("post_rd0", 1, 0, 4'b0000);
    chk("post_rd0_d", 32'(RdData), 32'h00);
    drv(0, 0, 0, 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_cfg.md
# regfile_cfg

Parametrised successor to the system register file. It holds DEPTH words of DATA_WIDTH bits, serves bus reads and writes from the system controller, and exposes the low N_EXPOSE registers as a flat bus. In the default build those are ALU operand A, ALU operand B, the UART config and the clock-divider config. New behaviour over the previous register file:
- per-register read-only mask,
- per-register reset values for the config slots,
- an error strobe for illegal accesses,
- change-detect update pulses so the UART and divider re-latch config only when it actually changes.

## Interface
Parameters:
- DATA_WIDTH, 8, word width.
- DEPTH, 16, number of registers; must be ≥ N_EXPOSE and ≥ 4.
- ADDR_WIDTH, 4, Address width; must be ≥ clog2(DEPTH).
- N_EXPOSE, 4, registers driven onto REG_OUT and CFG_UPD.
- RO_MASK, 0 (DEPTH bits), bit i = 1 makes register i read-only from the bus.
- REG2_RST, 8'h81, reset value of register 2 (UART config: parity enabled, even, prescale 32).
- REG3_RST, 8'h20, reset value of register 3 (clock-divider ratio 32).

Ports:
- CLK  in  1  system reference clock; all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- WrData  in  DATA_WIDTH  write data.
- Address  in  ADDR_WIDTH  register index.
- WR_En  in  1  write request, sampled each cycle.
- RD_EN  in  1  read request, sampled each cycle.
- RdData  out  DATA_WIDTH  registered read data.
- RdData_Vaild  out  1  one-cycle strobe, RdData valid.
- ERR  out  1  one-cycle strobe, illegal access rejected.
- CFG_UPD  out  N_EXPOSE  one-cycle per-register changed strobe.
- REG_OUT  out  N_EXPOSE*DATA_WIDTH  register i at [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Access decode, evaluated each cycle:
  - Legal write: WR_En=1, RD_EN=0, Address < DEPTH, RO_MASK[Address]=0.
  - Legal read: RD_EN=1, WR_En=0, Address < DEPTH.
- Legal write: mem[Address] ← WrData at the edge.
  - If Address < N_EXPOSE and WrData ≠ old mem[Address], CFG_UPD[Address] pulses high the next cycle.
  - Rewriting the same value produces no pulse.
- Legal read: RdData ← mem[Address]; RdData_Vaild pulses high the next cycle.
  - RdData holds its last value between reads.
- Illegal access: no state change and no RdData_Vaild; ERR pulses high the next cycle. Illegal cases:
  - both WR_En and RD_EN asserted;
  - Address ≥ DEPTH with either enable;
  - write to a read-only register.
- Idle (both enables low): no outputs pulse.
- Read-only registers keep their reset value permanently; they remain readable and remain on REG_OUT.
- REG_OUT is a continuous view of storage, with no extra register stage.
- Back-to-back accesses are accepted every cycle; there is no busy state.

## Timing
- Reset (RST=0, asynchronous assert, release synchronous to CLK):
  - every register is 0, except register 2 = REG2_RST and register 3 = REG3_RST;
  - RdData=0, RdData_Vaild=0, ERR=0, CFG_UPD=0.
- Reset mid-access: the in-flight operation is discarded; no strobe is produced after release.
- Write latency:
  - REG_OUT shows the new value from the cycle after the write edge;
  - CFG_UPD pulses in that same cycle, for exactly 1 cycle.
- Read latency: 1 cycle from RD_EN sampled to RdData/RdData_Vaild.
- Read of a register in the cycle after it is written returns the new value (no bypass needed; storage is already updated).
- ERR timing: asserted 1 cycle after the illegal request, for 1 cycle per illegal request. Consecutive illegal cycles keep ERR high continuously.
- At most one of RdData_Vaild, ERR, or a nonzero CFG_UPD is active in any cycle.

## Test plan
- Reset check → RdData=0, RdData_Vaild=0, ERR=0, CFG_UPD=0; REG_OUT = {8'h20, 8'h81, 8'h00, 8'h00} (MSB = register 3).
- Write 8'h5A to addr 0, then read addr 0 → CFG_UPD=4'b0001 for 1 cycle; next read gives RdData=8'h5A with RdData_Vaild=1 for 1 cycle.
- Write 8'h81 to addr 2 (same as reset value), then 8'h83 → no CFG_UPD pulse first; CFG_UPD=4'b0100 after the second write; REG_OUT[23:16]=8'h83.
- RO_MASK=16'h0002: write 8'hFF to addr 1 → ERR=1 for 1 cycle; addr 1 still reads 8'h00.
- Illegal cases → each gives ERR=1 with no RdData_Vaild: write to addr 16 with DEPTH=16; WR_En and RD_EN together on addr 0 (mem[0] unchanged). Back-to-back reads of addr 2, 3, 0 → RdData_Vaild high 3 consecutive cycles with 8'h81, 8'h20, 8'h00.
- Assert RST in the cycle after a read request → RdData_Vaild never pulses; all registers return to reset values.
